// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the sizing helper for the bit counter.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter must hold 0..WIDTH without wrapping inside one operation.
    function automatic int cnt_width(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Combinational 1-bit full adder; the single shared arithmetic cell that the
// serial controller time-multiplexes across all operand bits.
module fa_bit_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through
// one shared full-adder cell, with a start/busy/done handshake.
//
// Handshake: start is sampled on a rising edge only when busy is low (IDLE or
// DONE); that edge captures a, b and cin. busy is high for exactly WIDTH cycles,
// then done pulses for one cycle while sum/cout/ovf are valid. Results hold
// until the next accepting edge; start while busy is dropped, never queued.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_shift;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic             s_bit;
    logic             c_next;
    logic             accept;
    logic             run;
    logic             last_bit;

    fa_bit_cell u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (c_q),
        .s  (s_bit),
        .co (c_next)
    );

    assign run      = (state_q == ST_RUN);
    assign accept   = start && !run;
    assign last_bit = run && (cnt_q == LAST_BIT);

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB.
    if (WIDTH == 1) begin : g_sum_w1
        assign sum_shift = s_bit;
    end else begin : g_sum_wn
        assign sum_shift = {s_bit, sum_q[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand shifters, running carry, bit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            c_q   <= cin;
            cnt_q <= '0;
        end else if (run) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            sum_q <= sum_shift;
            c_q   <= c_next;
            cnt_q <= cnt_q + CW'(1);
            // c_q here is the carry into the MSB; c_next is the carry out of it.
            if (last_bit) begin
                cout_q <= c_next;
                ovf_q  <= c_q ^ c_next;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule
